// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared constants and types for the SPI mode-0 target: SPI mode encoding,
// byte and bit-counter widths, the default fill byte, and the frame state type.
// -----------------------------------------------------------------------------
package spi_pkg;

    // {CPOL, CPHA}; CPOL also gives the idle level of sclk.
    localparam logic [1:0] SPI_MODE0 = 2'b00;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = $clog2(BYTE_W);

    localparam logic [BYTE_W-1:0] DEFAULT_FILL_BYTE = 8'hFF;

    typedef enum logic {
        ST_IDLE,
        ST_SELECT
    } spi_state_e;

endpackage

// File: rtl/spi_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Brings one asynchronous pin into the clk domain through SYNC_STAGES flops
// (minimum 2) and flags its edges against one further registered copy.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous active-high reset (chain returns to RESET_VAL)
//   async_in  in   asynchronous pin
//   sync_out  out  synchronized level
//   rise      out  one-cycle pulse on a synchronized 0->1 transition
//   fall      out  one-cycle pulse on a synchronized 1->0 transition
// -----------------------------------------------------------------------------
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge value
    // of its neighbour; blocking here would collapse the chain into one flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;

endmodule

// File: rtl/spi_target.sv
// -----------------------------------------------------------------------------
// spi_target
// SPI mode-0 (CPOL=0, CPHA=0, MSB first) responder. The SPI pins are
// oversampled in the clk domain; received bytes appear as one-cycle pulses and
// transmit bytes enter through a single valid/ready holding register.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   sclk, cs_n     SPI clock and active-low select from the controller (async)
//   mosi           controller-to-target data (async)
//   miso, miso_oe  target-to-controller data and its tristate enable
//   i_tx_data      next byte to transmit, qualified by i_tx_valid
//   o_tx_ready     holding register empty
//   o_rx_data      last complete received byte, o_rx_valid pulses per byte
//   o_frame_err    pulse when cs_n rises in the middle of a byte
//   o_busy         target selected
// -----------------------------------------------------------------------------
module spi_target
    import spi_pkg::*;
#(
    parameter int                SYNC_STAGES = 2,
    parameter logic [BYTE_W-1:0] FILL_BYTE   = DEFAULT_FILL_BYTE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [BYTE_W-1:0] i_tx_data,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    output logic [BYTE_W-1:0] o_rx_data,
    output logic              o_rx_valid,
    output logic              o_frame_err,
    output logic              o_busy
);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_rise, cs_fall, cs_n_level_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(SPI_MODE0[1])) u_sync_sclk (
        .clk(clk), .rst(rst), .async_in(sclk),
        .sync_out(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk(clk), .rst(rst), .async_in(cs_n),
        .sync_out(cs_n_level_unused), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_in(mosi),
        .sync_out(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    spi_state_e           state_q, state_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]    rx_sh_q, rx_sh_d;
    logic [BYTE_W-1:0]    tx_sh_q, tx_sh_d;
    logic [BYTE_W-1:0]    hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [BYTE_W-1:0]    rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;

    logic                 tx_load;
    logic                 tx_write;
    logic [BYTE_W-1:0]    tx_next;

    // A consume sees the holding register as it was before any same-cycle
    // write, so a write into an empty register lands after FILL_BYTE is taken.
    assign tx_next  = hold_full_q ? hold_q : FILL_BYTE;
    assign tx_write = i_tx_valid && !hold_full_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every combinational output gets a default before any branch;
    // a path that leaves it unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cs_fall) state_d = ST_SELECT;
            ST_SELECT: if (cs_rise) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        miso    = 1'b1;
        miso_oe = 1'b0;
        o_busy  = 1'b0;
        if (state_q == ST_SELECT) begin
            miso    = tx_sh_q[BYTE_W-1];
            miso_oe = 1'b1;
            o_busy  = 1'b1;
        end
    end

    // ---------------- shift datapath and holding register ----------------
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        tx_load     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // sclk edges while deselected, including one coincident with
                // the select edge, are ignored.
                bit_cnt_d = '0;
                if (cs_fall) tx_load = 1'b1;
            end
            ST_SELECT: begin
                if (cs_rise) begin
                    frame_err_d = (bit_cnt_q != '0);
                    bit_cnt_d   = '0;
                    rx_sh_d     = '0;
                end else if (sclk_rise) begin
                    rx_sh_d   = {rx_sh_q[BYTE_W-2:0], mosi_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == BIT_CNT_W'(BYTE_W-1)) begin
                        rx_data_d  = rx_sh_d;
                        rx_valid_d = 1'b1;
                    end
                end else if (sclk_fall) begin
                    // Counter back at 0 after a falling edge means the byte
                    // just finished: fetch the next one instead of shifting.
                    if (bit_cnt_q != '0) tx_sh_d = tx_sh_q << 1;
                    else                 tx_load = 1'b1;
                end
            end
            default: ;
        endcase

        if (tx_load) tx_sh_d = tx_next;

        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        if (tx_load)  hold_full_d = 1'b0;
        if (tx_write) begin
            hold_d      = i_tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_tx_ready  = !hold_full_q;
    assign o_rx_data   = rx_data_q;
    assign o_rx_valid  = rx_valid_q;
    assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_target.sv
// -----------------------------------------------------------------------------
// tb_spi_target
// Drives spi_target as a mode-0 controller at clk/8 and compares against a
// byte-level model: a one-entry transmit holding register that is emptied at
// each select and each byte boundary (FILL when empty), plus expected queues
// of received bytes and frame-error pulses.
// -----------------------------------------------------------------------------
module tb_spi_target;

    localparam int        HALF = 4;       // sclk half period in clk cycles
    localparam logic [7:0] FILL = 8'hFF;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic [7:0] o_rx_data;
    logic       o_rx_valid, o_frame_err, o_busy;

    always #5 clk = ~clk;

    spi_target dut (
        .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid), .o_tx_ready(o_tx_ready),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .o_frame_err(o_frame_err), .o_busy(o_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    logic       m_full;
    logic [7:0] m_data;
    logic [7:0] exp_rx[$];
    int         exp_ferr;

    // Observed events.
    logic [7:0] rx_seen[$];
    int         ferr_seen;

    // Per-frame stimulus.
    logic [7:0] fr_mosi[4];
    logic [7:0] fr_wr_mask[4];
    logic [7:0] fr_wr_data[4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] model_pop();
        logic [7:0] b;
        b = m_full ? m_data : FILL;
        m_full = 1'b0;
        return b;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (o_rx_valid)  rx_seen.push_back(o_rx_data);
            if (o_frame_err) ferr_seen++;
        end
    end

    task automatic tx_offer(input logic [7:0] d);
        check("tx_ready", o_tx_ready, !m_full);
        i_tx_data  = d;
        i_tx_valid = 1'b1;
        clks(1);
        i_tx_valid = 1'b0;
        if (!m_full) begin
            m_full = 1'b1;
            m_data = d;
        end
    endtask

    // Shift nbits of one byte; offer wr_data during the high phase of every
    // bit whose position is set in wr_mask. mi collects miso sampled at rise.
    task automatic spi_byte(input logic [7:0] mo, input int nbits, input logic [7:0] wr_mask,
                            input logic [7:0] wr_data, output logic [7:0] mi);
        mi = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            clks(HALF);
            sclk = 1'b1;
            mi   = {mi[6:0], miso};
            if (wr_mask[7-i]) begin
                tx_offer(wr_data);
                clks(HALF-1);
            end else begin
                clks(HALF);
            end
            sclk = 1'b0;
        end
    endtask

    task automatic run_frame(input int nbytes, input int abort_bits);
        logic [7:0] cur, mi;
        int         nchk;
        cs_n = 1'b0;
        clks(8);
        cur = model_pop();
        check("oe_sel", miso_oe, 1'b1);
        check("busy_sel", o_busy, 1'b1);
        check("ready_sel", o_tx_ready, !m_full);
        for (int b = 0; b < nbytes; b++) begin
            spi_byte(fr_mosi[b], 8, fr_wr_mask[b], fr_wr_data[b], mi);
            check("miso_byte", mi, cur);
            exp_rx.push_back(fr_mosi[b]);
            cur = model_pop();
        end
        if (abort_bits > 0) begin
            spi_byte(fr_mosi[nbytes], abort_bits, 8'h00, 8'h00, mi);
            check("miso_partial", mi, cur >> (8 - abort_bits));
            exp_ferr++;
        end
        clks(4);
        cs_n = 1'b1;
        clks(8);
        check("busy_idle", o_busy, 1'b0);
        check("oe_idle", miso_oe, 1'b0);
        check("miso_idle", miso, 1'b1);
        check("rx_count", rx_seen.size(), exp_rx.size());
        nchk = (rx_seen.size() < exp_rx.size()) ? rx_seen.size() : exp_rx.size();
        for (int k = 0; k < nchk; k++) check("rx_byte", rx_seen[k], exp_rx[k]);
        rx_seen.delete();
        exp_rx.delete();
        check("frame_err_cnt", ferr_seen, exp_ferr);
        if (nbytes > 0) check("rx_data_hold", o_rx_data, fr_mosi[nbytes-1]);
    endtask

    task automatic clear_frame();
        for (int b = 0; b < 4; b++) begin
            fr_mosi[b]    = 8'h00;
            fr_wr_mask[b] = 8'h00;
            fr_wr_data[b] = 8'h00;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] cur, mi;
        int         nb, ab;

        rst = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        i_tx_data = '0; i_tx_valid = 1'b0;
        m_full = 1'b0; m_data = '0; exp_ferr = 0; ferr_seen = 0;
        clear_frame();
        clks(3);
        check("rst_miso", miso, 1'b1);
        check("rst_oe", miso_oe, 1'b0);
        check("rst_ready", o_tx_ready, 1'b1);
        check("rst_rx_data", o_rx_data, 8'h00);
        check("rst_rx_valid", o_rx_valid, 1'b0);
        check("rst_ferr", o_frame_err, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        rst = 1'b0;
        clks(2);

        // sclk toggling while deselected has no effect.
        repeat (4) begin
            sclk = 1'b1; mosi = 1'b1; clks(HALF);
            sclk = 1'b0; clks(HALF);
        end
        mosi = 1'b0;
        clks(4);
        check("idle_miso", miso, 1'b1);
        check("idle_oe", miso_oe, 1'b0);
        check("idle_rx", rx_seen.size(), 0);
        check("idle_ready", o_tx_ready, 1'b1);

        // Preloaded byte goes out, controller byte comes in.
        tx_offer(8'hA5);
        clks(2);
        check("preload_ready", o_tx_ready, 1'b0);
        clear_frame();
        fr_mosi[0] = 8'h3C;
        run_frame(1, 0);

        // Nothing held: FILL on both bytes.
        clear_frame();
        fr_mosi[0] = 8'hFF; fr_mosi[1] = 8'hFF;
        run_frame(2, 0);

        // 8'h11 loaded during byte 0 and a second offer refused while full;
        // 8'h22 accepted during byte 1.
        clear_frame();
        fr_mosi[0] = 8'h5A; fr_mosi[1] = 8'hC3; fr_mosi[2] = 8'h0F;
        fr_wr_mask[0] = 8'b0100_0100; fr_wr_data[0] = 8'h11;
        fr_wr_mask[1] = 8'b0001_0000; fr_wr_data[1] = 8'h22;
        run_frame(3, 0);

        // Abort after five bits, then a clean frame from bit 0.
        clear_frame();
        fr_mosi[0] = 8'hE7;
        run_frame(0, 5);
        clear_frame();
        fr_mosi[0] = 8'h81;
        run_frame(1, 0);

        // Reset mid-byte with a byte waiting in the holding register.
        tx_offer(8'h5A);
        cs_n = 1'b0;
        clks(8);
        cur = model_pop();
        spi_byte(8'h96, 3, 8'b0100_0000, 8'hC3, mi);
        check("pre_rst_partial", mi, cur >> 5);
        sclk = 1'b1;
        clks(1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_miso", miso, 1'b1);
        check("mid_rst_oe", miso_oe, 1'b0);
        check("mid_rst_ready", o_tx_ready, 1'b1);
        check("mid_rst_rx_data", o_rx_data, 8'h00);
        check("mid_rst_rx_valid", o_rx_valid, 1'b0);
        check("mid_rst_ferr", o_frame_err, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        m_full = 1'b0;
        clks(3);
        rst = 1'b0;
        rx_seen.delete();
        exp_rx.delete();
        ferr_seen = 0;
        exp_ferr  = 0;
        clks(2);
        clear_frame();
        fr_mosi[0] = 8'h3D;
        run_frame(1, 0);

        // Randomized frames.
        for (int f = 0; f < 14; f++) begin
            nb = $urandom_range(1, 3);
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            for (int b = 0; b < 4; b++) begin
                fr_mosi[b]    = 8'($urandom);
                fr_wr_mask[b] = 8'($urandom & $urandom);
                fr_wr_data[b] = 8'($urandom);
            end
            run_frame(nb, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_target.md
Name: spi_target

Overview:
- SPI mode-0 responder (CPOL=0, CPHA=0, MSB first). It is the far end of the SPI controller on the processor bus.
- Oversamples external sclk/cs_n/mosi in the system clock domain and drives miso.
- Presents received bytes to internal logic as single-cycle pulses. Accepts transmit bytes through a valid/ready holding register.
- Used as the bus-side stand-in for SD/flash peripherals and in loopback tests of the controller.

Parameters:
- SYNC_STAGES, 2, number of flops in each input synchronizer (minimum 2).
- FILL_BYTE, 8'hFF, byte shifted out when no transmit data is held.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sclk  in  1  SPI clock from controller; async to clk; frequency ≤ clk/4.
- cs_n  in  1  chip select, active low; async.
- mosi  in  1  controller-to-target data; async.
- miso  out  1  target-to-controller data.
- miso_oe  out  1  1 while selected (synced cs_n low); for external tristate.
- i_tx_data  in  8  next byte to transmit.
- i_tx_valid  in  1  i_tx_data valid.
- o_tx_ready  out  1  holding register empty.
- o_rx_data  out  8  last complete received byte; holds until next byte.
- o_rx_valid  out  1  one-cycle pulse per received byte.
- o_frame_err  out  1  one-cycle pulse when cs_n rises mid-byte.
- o_busy  out  1  selected (synced cs_n low).

Behaviour:
- Reset (async): all synchronizer flops to idle (sclk=0, cs_n=1, mosi=0). Outputs: miso=1, miso_oe=0, o_tx_ready=1, o_rx_data=0, o_rx_valid=0, o_frame_err=0, o_busy=0. bit_cnt=0, shifters=0, holding register empty.
- Synchronization: each input passes SYNC_STAGES flops. Edges are detected against one further registered copy. Latency from pin to internal event is SYNC_STAGES+1 clk.
- States:
  - IDLE (cs high): bit_cnt held at 0; miso=1; miso_oe=0.
  - SELECT (cs low): active shifting.
- IDLE→SELECT on synced cs_n falling edge:
  - Load tx shifter from holding register if full (holding becomes empty, o_tx_ready=1 next cycle); else load FILL_BYTE.
  - miso = shifter[7] from the next cycle.
- sclk rising edge in SELECT:
  - rx_sh <= {rx_sh[6:0], mosi_sync}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7→0).
  - When bit_cnt was 7: o_rx_data <= {rx_sh[6:0], mosi_sync} and o_rx_valid=1 on the same registered update (1 cycle).
- sclk falling edge in SELECT:
  - If bit_cnt != 0: tx_sh <= tx_sh<<1.
  - If bit_cnt == 0 (byte boundary): reload tx_sh from holding register or FILL_BYTE, as at select.
  - miso follows tx_sh[7].
- No rx backpressure: a byte not consumed is overwritten by the next.
- Holding register: write when i_tx_valid && o_tx_ready. A consume (select or boundary load) samples the register's pre-write contents. If write and consume fall in the same cycle with the register empty, FILL_BYTE is sent and the written byte remains held for the next byte.
- SELECT→IDLE on synced cs_n rising edge:
  - If bit_cnt != 0: o_frame_err pulses 1 cycle, partial rx byte discarded, no o_rx_valid.
  - bit_cnt=0; holding register contents retained.
- sclk edges while in IDLE are ignored. cs_n fall and sclk edge detected in the same cycle: select processing only; the sclk edge is ignored.
- Reset asserted mid-frame: immediate return to reset values; held tx byte lost.

Decomposition:
- Shared package spi_pkg: SPI_MODE0 constant, byte width (8), default FILL_BYTE, bit-counter width.
- One sub-module spi_sync_edge: N-stage synchronizer plus rise/fall pulse outputs. Instantiated three times (sclk, cs_n, mosi; edge outputs unused for mosi).

Test Plan:
- Reset, cs_n high, toggle sclk → miso=1, miso_oe=0, no o_rx_valid, o_tx_ready=1.
- Preload 8'hA5, select, controller sends 8'h3C at clk/8 → o_rx_data=8'h3C with one o_rx_valid pulse; controller samples 8'hA5 on miso; o_tx_ready high after select.
- No tx data, 2-byte frame with mosi=1 (8'hFF,8'hFF) → miso returns 8'hFF,8'hFF; o_rx_valid pulses twice.
- Load 8'h11 during byte 0, 8'h22 offered during byte 1 (ready low until byte-1 boundary) → miso bytes FILL,8'h11,8'h22 across a 3-byte frame.
- cs_n raised after 5 sclk rises → o_frame_err one pulse, no o_rx_valid; next frame receives 8'h81 correctly from bit 0.
- rst asserted mid-byte with held byte → all outputs at reset values within the same cycle; post-reset frame sends FILL_BYTE.
